// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF (read-only) and DM (read/write) onto one memory port.
// Define ROUND_ROBIN_EN for round-robin conflict arbitration; default is DM priority.
module mem_port_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_ack,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_dm_req,
  input  logic          i_dm_we,
  input  logic [AW-1:0] i_dm_addr,
  input  logic [DW-1:0] i_dm_wdata,
  output logic          o_dm_ack,
  output logic [DW-1:0] o_dm_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_we,
  output logic          o_mem_clk,
  input  logic [DW-1:0] i_mem_out,
  output logic [1:0]    o_grant,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);
  localparam logic [1:0] G_NONE   = 2'b00;
  localparam logic [1:0] G_IF     = 2'b01;
  localparam logic [1:0] G_DM     = 2'b10;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          r_wr;
  logic          w_wr_nxt;
  logic          w_win_if;
  logic          w_win_dm;
  logic          w_if_ack_nxt;
  logic          w_dm_ack_nxt;
  logic [DW-1:0] w_if_rdata_nxt;
  logic [DW-1:0] w_dm_rdata_nxt;
  logic [AW-1:0] w_mem_addr_nxt;
  logic [DW-1:0] w_mem_wdata_nxt;
  logic          w_mem_we_nxt;
  logic          w_mem_clk_nxt;
  logic [1:0]    w_grant_nxt;
  logic          w_busy_nxt;

`ifdef ROUND_ROBIN_EN
  logic r_last_dm;
  logic w_last_dm_nxt;

  // On a conflict the requester not served last wins.
  assign w_win_if = i_if_req & (~i_dm_req | r_last_dm);
  assign w_last_dm_nxt = (r_state == S_IDLE && (w_win_if || w_win_dm)) ?
                         w_win_dm : r_last_dm;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_last_dm <= 1'b1;
    else       r_last_dm <= w_last_dm_nxt;
  end
`else
  assign w_win_if = i_if_req & ~i_dm_req;
`endif
  assign w_win_dm = i_dm_req & ~w_win_if;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      o_if_ack    <= 1'b0;
      o_dm_ack    <= 1'b0;
      o_if_rdata  <= '0;
      o_dm_rdata  <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_we    <= 1'b0;
      o_mem_clk   <= 1'b0;
      o_grant     <= G_NONE;
      o_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wr        <= w_wr_nxt;
      o_if_ack    <= w_if_ack_nxt;
      o_dm_ack    <= w_dm_ack_nxt;
      o_if_rdata  <= w_if_rdata_nxt;
      o_dm_rdata  <= w_dm_rdata_nxt;
      o_mem_addr  <= w_mem_addr_nxt;
      o_mem_wdata <= w_mem_wdata_nxt;
      o_mem_we    <= w_mem_we_nxt;
      o_mem_clk   <= w_mem_clk_nxt;
      o_grant     <= w_grant_nxt;
      o_busy      <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    w_cnt_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_win_if || w_win_dm) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs; captured fields hold by default.
  always_comb begin
    w_mem_addr_nxt  = o_mem_addr;
    w_mem_wdata_nxt = o_mem_wdata;
    w_mem_we_nxt    = 1'b0;
    w_mem_clk_nxt   = 1'b0;
    w_grant_nxt     = o_grant;
    w_wr_nxt        = r_wr;
    w_if_ack_nxt    = 1'b0;
    w_dm_ack_nxt    = 1'b0;
    w_if_rdata_nxt  = o_if_rdata;
    w_dm_rdata_nxt  = o_dm_rdata;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_win_if) begin
          w_mem_addr_nxt = i_if_addr;
          w_wr_nxt       = 1'b0;
          w_mem_clk_nxt  = 1'b1;
          w_grant_nxt    = G_IF;
        end else if (w_win_dm) begin
          w_mem_addr_nxt  = i_dm_addr;
          w_mem_wdata_nxt = i_dm_wdata;
          w_mem_we_nxt    = i_dm_we;
          w_wr_nxt        = i_dm_we;
          w_mem_clk_nxt   = 1'b1;
          w_grant_nxt     = G_DM;
        end
      end
      S_WAIT: begin
        if (w_state_nxt == S_RESP) begin
          if (o_grant == G_IF) begin
            w_if_ack_nxt   = 1'b1;
            w_if_rdata_nxt = i_mem_out;
          end else begin
            w_dm_ack_nxt = 1'b1;
            if (!r_wr) w_dm_rdata_nxt = i_mem_out;
          end
        end
      end
      S_RESP:  w_grant_nxt = G_NONE;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter.
// Instance u_dut runs MEM_LAT=1, u_dut3 runs MEM_LAT=3.
module tb_mem_port_arbiter;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } op_t;

  logic        clk;
  logic        rst;
  logic        if_req, if_ack;
  logic [15:0] if_addr;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we, dm_ack;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_out;
  logic        mem_we, mem_clk, busy;
  logic [1:0]  grant;

  logic        if_req3, if_ack3, dm_req3, dm_we3, dm_ack3;
  logic [15:0] if_addr3, dm_addr3, mem_addr3;
  logic [31:0] if_rdata3, dm_wdata3, dm_rdata3, mem_wdata3, mem_out3;
  logic        mem_we3, mem_clk3, busy3;
  logic [1:0]  grant3;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_we = 0;
  logic [31:0] dm_hold = '0;

  op_t         if_ops[$];
  op_t         dm_ops[$];
  logic [31:0] sb_if[$];
  logic [31:0] sb_dm[$];
  int          ord[$];
  int          ackc[$];
  logic [15:0] iss_log[$];

  mem_port_arbiter #(.AW(16), .DW(32), .MEM_LAT(1)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_ack(if_ack), .o_if_rdata(if_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we),
    .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_ack(dm_ack), .o_dm_rdata(dm_rdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_we(mem_we), .o_mem_clk(mem_clk),
    .i_mem_out(mem_out), .o_grant(grant), .o_busy(busy)
  );

  mem_port_arbiter #(.AW(16), .DW(32), .MEM_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req3), .i_if_addr(if_addr3),
    .o_if_ack(if_ack3), .o_if_rdata(if_rdata3),
    .i_dm_req(dm_req3), .i_dm_we(dm_we3),
    .i_dm_addr(dm_addr3), .i_dm_wdata(dm_wdata3),
    .o_dm_ack(dm_ack3), .o_dm_rdata(dm_rdata3),
    .o_mem_addr(mem_addr3), .o_mem_wdata(mem_wdata3),
    .o_mem_we(mem_we3), .o_mem_clk(mem_clk3),
    .i_mem_out(mem_out3), .o_grant(grant3), .o_busy(busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model, latency 1: data valid in the cycle after the strobe.
  logic [31:0] mem [256];
  logic        loaded = 1'b0;
  int          cnt = 0;
  logic [31:0] rd;
  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
      mem[4] = 32'hDEAD_BEEF;
      loaded = 1'b1;
    end
    mem_out = 32'hBAD0_BAD0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) mem_out = rd;
    end
    if (mem_clk) begin
      if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
      else begin
        rd  = mem[mem_addr[7:0]];
        cnt = 1;
      end
    end
  end

  int          cnt3 = 0;
  logic [15:0] rd3;
  always @(negedge clk) begin
    mem_out3 = 32'hBAD0_BAD0;
    if (cnt3 > 0) begin
      cnt3--;
      if (cnt3 == 0) mem_out3 = {16'h3C3C, rd3};
    end
    if (mem_clk3) begin
      rd3  = mem_addr3;
      cnt3 = 3;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add_if(input logic [15:0] a, input logic [31:0] e);
    op_t o;
    o.we = 1'b0; o.addr = a; o.data = '0; o.exp = e;
    if_ops.push_back(o);
  endtask

  task automatic add_dm(input logic we, input logic [15:0] a,
                        input logic [31:0] d, input logic [31:0] e);
    op_t o;
    o.we = we; o.addr = a; o.data = d;
    if (!we) dm_hold = e;
    o.exp = dm_hold;
    dm_ops.push_back(o);
  endtask

  task automatic present_if();
    if (if_ops.size() > 0) begin
      if_req  = 1'b1;
      if_addr = if_ops[0].addr;
      sb_if.push_back(if_ops[0].exp);
    end else if_req = 1'b0;
  endtask

  task automatic present_dm();
    if (dm_ops.size() > 0) begin
      dm_req   = 1'b1;
      dm_we    = dm_ops[0].we;
      dm_addr  = dm_ops[0].addr;
      dm_wdata = dm_ops[0].data;
      sb_dm.push_back(dm_ops[0].exp);
    end else dm_req = 1'b0;
  endtask

  task automatic serve(input string tag);
    int n = 0;
    if (!if_req) present_if();
    if (!dm_req) present_dm();
    while ((if_req || dm_req || busy) && n < 60) begin
      @(negedge clk);
      n++;
      if (mem_clk) iss_log.push_back(mem_addr);
      if (mem_we) begin
        n_we++;
        check("we_with_strobe", {31'd0, mem_clk}, 32'd1);
      end
      if (if_ack) begin
        if (sb_if.size() == 0) check("spurious_if_ack", 32'd1, 32'd0);
        else check("if_rdata", if_rdata, sb_if.pop_front());
        check("if_grant", {30'd0, grant}, 32'd1);
        ord.push_back(0);
        ackc.push_back(cyc);
        if (if_ops.size() > 0) void'(if_ops.pop_front());
        present_if();
      end
      if (dm_ack) begin
        if (sb_dm.size() == 0) check("spurious_dm_ack", 32'd1, 32'd0);
        else check("dm_rdata", dm_rdata, sb_dm.pop_front());
        check("dm_grant", {30'd0, grant}, 32'd2);
        ord.push_back(1);
        if (dm_ops.size() > 0) void'(dm_ops.pop_front());
        present_dm();
      end
    end
    check({"done_", tag}, {31'd0, n < 60}, 32'd1);
  endtask

  initial begin
    int nb;
    int first;
    rst = 1'b1;
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    if_req3 = 0; if_addr3 = '0;
    dm_req3 = 0; dm_we3 = 0; dm_addr3 = '0; dm_wdata3 = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_clk", {31'd0, mem_clk}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // IF read of mem[4], cycle by cycle.
    if_req = 1'b1; if_addr = 16'h0004;
    @(negedge clk);
    check("t1_issue_strobe", {31'd0, mem_clk}, 32'd1);
    check("t1_issue_addr", {16'd0, mem_addr}, 32'd4);
    check("t1_issue_grant", {30'd0, grant}, 32'd1);
    check("t1_issue_ack", {31'd0, if_ack}, 32'd0);
    @(negedge clk);
    check("t1_wait_strobe", {31'd0, mem_clk}, 32'd0);
    check("t1_wait_grant", {30'd0, grant}, 32'd1);
    check("t1_wait_ack", {31'd0, if_ack}, 32'd0);
    @(negedge clk);
    check("t1_resp_ack", {31'd0, if_ack}, 32'd1);
    check("t1_resp_rdata", if_rdata, 32'hDEAD_BEEF);
    check("t1_resp_grant", {30'd0, grant}, 32'd1);
    if_req = 1'b0;
    @(negedge clk);
    check("t1_idle_ack", {31'd0, if_ack}, 32'd0);
    check("t1_idle_grant", {30'd0, grant}, 32'd0);
    check("t1_idle_busy", {31'd0, busy}, 32'd0);

    // MEM_LAT=3 instance: ACK in cycle t+5, BUSY for 5 cycles.
    if_req3 = 1'b1; if_addr3 = 16'h0007;
    nb = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      nb += int'(busy3);
      check("t4_ack_timing", {31'd0, if_ack3}, {31'd0, k == 5});
      if (k == 1) check("t4_strobe", {31'd0, mem_clk3}, 32'd1);
      if (k == 5) begin
        check("t4_rdata", if_rdata3, 32'h3C3C_0007);
        if_req3 = 1'b0;
      end
    end
    check("t4_busy_cycles", nb, 32'd5);

    // DM write then read of the same word.
    n_we = 0;
    add_dm(1'b1, 16'h0010, 32'h1234_5678, '0);
    add_dm(1'b0, 16'h0010, '0, 32'h1234_5678);
    serve("t2");
    check("t2_we_cycles", n_we, 32'd1);

    // Conflicts: IF+DM together, a lone IF, then IF+DM again.
`ifdef ROUND_ROBIN_EN
    first = 0;
`else
    first = 1;
`endif
    ord.delete();
    add_if(16'h0008, 32'hC0DE_0008);
    add_dm(1'b1, 16'h0020, 32'hAAAA_5555, '0);
    serve("t3a");
    check("t3a_count", ord.size(), 32'd2);
    check("t3a_first", ord[0], first);
    check("t3a_second", ord[1], 1 - first);
    add_if(16'h0005, 32'hC0DE_0005);
    serve("t3b");
    ord.delete();
    add_if(16'h0020, 32'hAAAA_5555);
    add_dm(1'b0, 16'h0004, '0, 32'hDEAD_BEEF);
    serve("t3c");
    check("t3c_count", ord.size(), 32'd2);
    check("t3c_first", ord[0], 32'd1);
    check("t3c_second", ord[1], 32'd0);

    // Reset while an IF read sits in WAIT.
    if_req = 1'b1; if_addr = 16'h0003;
    repeat (2) @(negedge clk);
    check("t5_in_wait", {30'd0, busy, mem_clk}, 32'd2);
    rst = 1'b1;
    if_req = 1'b0;
    #1;
    check("t5_grant", {30'd0, grant}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_strobe", {30'd0, mem_clk, mem_we}, 32'd0);
    check("t5_if_rdata", if_rdata, 32'd0);
    nb = 0;
    repeat (3) begin
      @(negedge clk);
      nb += int'(if_ack);
    end
    check("t5_no_ack", nb, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    dm_hold = '0;
    add_if(16'h0001, 32'hC0DE_0001);
    serve("t5_after");

    // Back-to-back IF reads with REQ held high.
    ackc.delete();
    iss_log.delete();
    add_if(16'h0000, 32'hC0DE_0000);
    add_if(16'h0001, 32'hC0DE_0001);
    add_if(16'h0002, 32'hC0DE_0002);
    serve("t6");
    check("t6_acks", ackc.size(), 32'd3);
    check("t6_gap1", ackc[1] - ackc[0], 32'd4);
    check("t6_gap2", ackc[2] - ackc[1], 32'd4);
    check("t6_addr0", {16'd0, iss_log[0]}, 32'd0);
    check("t6_addr1", {16'd0, iss_log[1]}, 32'd1);
    check("t6_addr2", {16'd0, iss_log[2]}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
